// File: rtl/weight_reader.sv
// weight_reader
//   Drain side of the eigenface-projection accumulator bank. A start pulse
//   snapshots the whole bank and pulses acc_clear so the bank can begin the
//   next face. The snapshot is then streamed one word per beat over a
//   valid/ready interface, with a running 32-bit checksum of transferred words.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   start      : capture-and-drain request (one-cycle pulse)
//   data_in    : accumulator bank contents, NUM_WEIGHTS x DATA_W
//   acc_clear  : one-cycle clear pulse to the bank, cycle after start accept
//   out_valid  : stream word available
//   out_ready  : downstream accepts the word
//   out_data   : current weight word
//   out_index  : index of the current word
//   out_sop    : first word of frame
//   out_eop    : last word of frame
//   busy       : streaming in progress
//   done       : one-cycle pulse after the last word is accepted
//   checksum   : modulo-2^DATA_W sum of words transferred in this/last frame
//   start_err  : sticky, start seen while busy (cleared only by rst)
//
// state  | meaning
// IDLE   | waiting for start; no word offered
// STREAM | offering snapshot[index]; last transfer returns to IDLE
module weight_reader #(
  parameter int NUM_WEIGHTS = 240,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_WEIGHTS-1:0][DATA_W-1:0]  data_in,
  output logic                                acc_clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_data,
  output logic [IDX_W-1:0]                    out_index,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic                                busy,
  output logic                                done,
  output logic [DATA_W-1:0]                   checksum,
  output logic                                start_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                              state, state_nxt;
  logic [NUM_WEIGHTS-1:0][DATA_W-1:0]  snapshot;
  logic [IDX_W-1:0]                    index;
  logic                                start_acc;
  logic                                xfer;
  logic                                last;

  assign last = (index == LAST_IDX);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    xfer      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (last) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc_clear <= 1'b0;
      done      <= 1'b0;
      index     <= '0;
      checksum  <= '0;
      start_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_clear <= start_acc;
      done      <= xfer & last;
      if (start_acc) begin
        index    <= '0;
        checksum <= '0;
      end else if (xfer) begin
        checksum <= checksum + out_data;
        // index parks on the last word after the frame; it is reloaded on start
        if (!last) index <= index + 1'b1;
      end
      if (start && (state == S_STREAM)) start_err <= 1'b1;
    end
  end

  // Snapshot needs no reset: it is only observed after a capture.
  always_ff @(posedge clk) begin
    if (start_acc) snapshot <= data_in;
  end

  assign out_valid = (state == S_STREAM);
  assign busy      = (state == S_STREAM);
  assign out_data  = snapshot[index];
  assign out_index = index;
  assign out_sop   = out_valid & (index == '0);
  assign out_eop   = out_valid & last;

endmodule

// File: tb/tb_weight_reader.sv
module tb_weight_reader;

  localparam int N  = 240;
  localparam int DW = 32;
  localparam int IW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [N-1:0][DW-1:0] data_in;
  logic                 acc_clear;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_data;
  logic [IW-1:0]        out_index;
  logic                 out_sop;
  logic                 out_eop;
  logic                 busy;
  logic                 done;
  logic [DW-1:0]        checksum;
  logic                 start_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] chk_q[$];

  int errors = 0;
  int checks = 0;
  int valid_total = 0;

  bit         ready_mode = 1'b0;
  logic [3:0] ready_pat = 4'b1001;
  int         rcnt = 0;

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_idx;
  logic          prev_sop, prev_eop;

  weight_reader #(.NUM_WEIGHTS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .acc_clear(acc_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_sop(out_sop),
    .out_eop(out_eop), .busy(busy), .done(done), .checksum(checksum),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready generator: all-ones, or repeating 1,0,0,1
  always @(posedge clk) begin
    #1;
    if (ready_mode) begin
      out_ready = ready_pat[rcnt];
      rcnt = (rcnt + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, prev_data);
        chk("stall_index", {24'd0, out_index}, {24'd0, prev_idx});
        chk("stall_sopeop", {30'd0, out_sop, out_eop}, {30'd0, prev_sop, prev_eop});
      end
      if (out_valid) valid_total++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got index %0d expected no beat", out_index);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_index", {24'd0, out_index}, {24'd0, b.idx});
          chk("beat_sop", {31'd0, out_sop}, {31'd0, b.sop});
          chk("beat_eop", {31'd0, out_eop}, {31'd0, b.eop});
        end
      end
      if (done) begin
        if (chk_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          chk("checksum", checksum, chk_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      prev_sop   = out_sop;
      prev_eop   = out_eop;
    end
  end

  task automatic set_ramp();
    for (int i = 0; i < N; i++) data_in[i] = DW'(i + 1);
  endtask

  task automatic push_frame(input logic [DW-1:0] exp_sum);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.data = data_in[i];
      b.idx  = IW'(i);
      b.sop  = (i == 0);
      b.eop  = (i == N - 1);
      exp_q.push_back(b);
    end
    chk_q.push_back(exp_sum);
  endtask

  // pulse start for one edge; returns in the first cycle after acceptance
  task automatic do_start(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_acc_clear"}, {31'd0, acc_clear}, 32'd1);
    chk({tag, "_first"}, {29'd0, out_valid, busy, out_sop}, 32'd7);
    chk({tag, "_idx0"}, {24'd0, out_index}, 32'd0);
  endtask

  // waits on negedges for done; returns in the done cycle
  task automatic wait_done(input string tag, input int budget, output int clr_seen);
    bit seen = 1'b0;
    clr_seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (acc_clear) clr_seen++;
      if (done) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) chk({tag, "_done_cycle"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    int clr;
    int v0;
    bit found;

    set_ramp();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", {27'd0, out_valid, busy, done, acc_clear, start_err}, 32'd0);
    chk("reset_checksum", checksum, 32'd0);
    chk("reset_index", {24'd0, out_index}, 32'd0);

    // basic drain
    push_frame(32'd28920);
    v0 = valid_total;
    do_start("basic");
    @(posedge clk); #1;
    chk("basic_clear_single", {31'd0, acc_clear}, 32'd0);
    wait_done("basic", 400, clr);
    chk("basic_valid_cycles", valid_total - v0, N);
    repeat (3) @(posedge clk);
    #1 chk("basic_checksum_hold", checksum, 32'd28920);

    // backpressure
    ready_mode = 1'b1;
    push_frame(32'd28920);
    do_start("bp");
    wait_done("bp", 1200, clr);
    ready_mode = 1'b0;

    // snapshot isolation
    push_frame(32'd28920);
    do_start("iso");
    for (int i = 0; i < N; i++) data_in[i] = 32'hFFFF_FFFF;
    wait_done("iso", 400, clr);

    // checksum wrap-around
    for (int i = 0; i < N; i++) data_in[i] = 32'd0;
    data_in[0] = 32'h8000_0000;
    data_in[1] = 32'h8000_0000;
    push_frame(32'd0);
    do_start("wrap");
    wait_done("wrap", 400, clr);

    // start while busy, then start in the done cycle
    set_ramp();
    push_frame(32'd28920);
    do_start("busy");
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (out_index == 8'd10) found = 1'b1;
    end
    chk("busy_reach_beat10", {31'd0, found}, 32'd1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_start_err", {31'd0, start_err}, 32'd1);
    wait_done("busy", 400, clr);
    chk("busy_no_second_clear", clr, 0);
    start = 1'b1;
    push_frame(32'd28920);
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_sop", {30'd0, out_valid, out_sop}, 32'd3);
    chk("b2b_acc_clear", {31'd0, acc_clear}, 32'd1);
    wait_done("b2b", 400, clr);
    chk("start_err_sticky", {31'd0, start_err}, 32'd1);

    // reset mid-frame
    push_frame(32'd28920);
    do_start("rstmid");
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (out_index == 8'd100) found = 1'b1;
    end
    chk("rstmid_reach_beat100", {31'd0, found}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    chk_q.delete();
    chk("rstmid_state", {27'd0, out_valid, busy, done, acc_clear, start_err}, 32'd0);
    chk("rstmid_checksum", checksum, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    push_frame(32'd28920);
    do_start("after_rst");
    wait_done("after_rst", 400, clr);

    repeat (3) @(posedge clk);
    #1;
    chk("beats_left", exp_q.size(), 32'd0);
    chk("sums_left", chk_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/weight_reader.md
# weight_reader

Drain side of the eigenface-projection accumulator bank. On a start pulse it snapshots the full bank of NUM_WEIGHTS 32-bit accumulated weights and pulses the bank's clear. It then streams the snapshot out one word per beat over a valid/ready interface toward the PCIe/Avalon bridge, so the bank can start accumulating the next face while results drain. It also produces a running 32-bit checksum of the streamed words for host-side integrity checking.

## Interface
Parameters:
- NUM_WEIGHTS, 240: number of accumulated weights in the bank (≥ 2).
- DATA_W, 32: width of each weight word.
- IDX_W, 8: width of the index output; must satisfy 2^IDX_W ≥ NUM_WEIGHTS.

Ports:
- clk  in  1: single clock for the whole block.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request to capture and drain; one-cycle pulse.
- data_in  in  [NUM_WEIGHTS-1:0][DATA_W-1:0]: accumulator bank contents.
- acc_clear  out  1: one-cycle clear pulse to the accumulator bank.
- out_valid  out  1: stream word available.
- out_ready  in  1: downstream accepts the word.
- out_data  out  DATA_W: current weight word.
- out_index  out  IDX_W: index of the current word.
- out_sop  out  1: first word of the frame (index 0).
- out_eop  out  1: last word of the frame (index NUM_WEIGHTS-1).
- busy  out  1: capture/stream in progress.
- done  out  1: one-cycle pulse after the last word is accepted.
- checksum  out  DATA_W: sum of the words transferred in the current or last frame.
- start_err  out  1: sticky flag, set when start arrives while busy.

## Operation
- States:
  - IDLE: busy=0, out_valid=0. An accepted start moves to STREAM.
  - STREAM: busy=1, out_valid=1. The last transfer returns to IDLE.
- Start accept: start=1 in IDLE. At that edge:
  - snapshot ← data_in (all words);
  - index ← 0;
  - checksum ← 0;
  - state ← STREAM.
- acc_clear is high for exactly one cycle, the cycle following start acceptance. It is registered and never combinational from start.
- Transfer: at an edge where out_valid & out_ready:
  - checksum ← checksum + out_data, modulo 2^DATA_W, carry discarded;
  - if index = NUM_WEIGHTS-1: state ← IDLE and done ← 1 for the next cycle;
  - otherwise index ← index+1.
- Output decode:
  - out_data = snapshot[index];
  - out_sop = out_valid & (index==0);
  - out_eop = out_valid & (index==NUM_WEIGHTS-1).
- Stall rule: while out_valid=1 and out_ready=0, out_data, out_index, out_sop and out_eop hold stable. out_valid never drops before the transfer.
- start while in STREAM is ignored: snapshot, index and checksum are unchanged, no acc_clear, and start_err is set. start_err clears only on rst.
- start in the done cycle is accepted (the state is already IDLE). This gives back-to-back frames with one idle cycle between the last beat and the new sop.
- The snapshot is isolated: changes on data_in after capture, including the cleared bank, do not affect streamed words.
- Reset at any point:
  - state IDLE;
  - out_valid=0, acc_clear=0, done=0, busy=0;
  - index=0, checksum=0, start_err=0;
  - snapshot contents are don't-care;
  - an in-flight frame is abandoned with no done and no clear.
- out_ready is ignored in IDLE.

## Timing
- Start accepted at edge t:
  - cycle t+1: acc_clear=1, out_valid=1, out_index=0, out_sop=1, busy=1.
- Latency from start to the first word offered is one cycle.
- Throughput is one word per cycle while out_ready=1. A frame with ready held high takes NUM_WEIGHTS cycles of out_valid.
- Last transfer at edge e:
  - cycle e+1: done=1, busy=0, out_valid=0, and checksum is final.
  - checksum holds until the next accepted start.
- done and acc_clear are single-cycle pulses, never extended by out_ready.
- All outputs are registered state or decodes of registered state. There is no combinational path from out_ready or start to any output.

## Test plan
- Basic drain:
  - Stimulus: data_in[i]=i+1, start, out_ready held 1.
  - Required response: acc_clear at t+1; 240 beats with indices 0..239 and data 1..240; sop on index 0, eop on index 239; done at the cycle after beat 239; checksum=28920.
- Backpressure:
  - Stimulus: as the basic drain, with out_ready toggling 1,0,0,1 repeatedly.
  - Required response: out_data/out_index stable across stalls; no duplicated or lost index; checksum=28920.
- Snapshot isolation:
  - Stimulus: drive data_in to all 0xFFFFFFFF one cycle after start.
  - Required response: streamed words are still i+1.
- Wrap-around:
  - Stimulus: data_in[0]=data_in[1]=0x80000000, all others 0.
  - Required response: checksum=0x00000000 at done.
- Start while busy:
  - Stimulus: start at beat 10.
  - Required response: start_err=1 (sticky); no second acc_clear; the frame completes unchanged. Then a start in the done cycle is accepted, with sop one cycle later.
- Reset mid-frame:
  - Stimulus: rst at beat 100.
  - Required response: the next cycle has out_valid=0, busy=0, done=0, checksum=0, start_err=0. A new start afterwards streams from index 0.
